// File: rtl/issue_queue.sv
// Compacting issue queue: buffers renamed micro-ops, wakes them on the
// writeback tag and issues the oldest one whose sources are both ready.
module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6,
    parameter int CTRL_W = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [PREG_W-1:0] disp_rd,
    input  logic [PREG_W-1:0] disp_rs1,
    input  logic              disp_rs1_rdy,
    input  logic [PREG_W-1:0] disp_rs2,
    input  logic              disp_rs2_rdy,
    input  logic [ROB_W-1:0]  disp_rob_idx,
    input  logic [CTRL_W-1:0] disp_ctrl,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_preg,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [PREG_W-1:0] issue_rd,
    output logic [PREG_W-1:0] issue_rs1,
    output logic [PREG_W-1:0] issue_rs2,
    output logic [ROB_W-1:0]  issue_rob_idx,
    output logic [CTRL_W-1:0] issue_ctrl,
    output logic [CNT_W-1:0]  count
);

    typedef struct packed {
        logic [PREG_W-1:0] rd;
        logic [PREG_W-1:0] rs1;
        logic              rs1_rdy;
        logic [PREG_W-1:0] rs2;
        logic              rs2_rdy;
        logic [ROB_W-1:0]  rob_idx;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t           ent_q   [DEPTH];
    entry_t           ent_d   [DEPTH];
    entry_t           ent_ext [DEPTH+1];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH:0]   vld_ext;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] widx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             disp_fire;
    logic             issue_fire;
    entry_t           new_ent;

    assign count      = cnt_q;
    assign disp_ready = (cnt_q < CNT_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready;
    assign issue_fire = sel_found && issue_ready;
    assign widx       = cnt_q - CNT_W'(issue_fire);

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        issue_valid   = sel_found;
        issue_rd      = '0;
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_rob_idx = '0;
        issue_ctrl    = '0;
        if (sel_found) begin
            issue_rd      = ent_q[sel_idx].rd;
            issue_rs1     = ent_q[sel_idx].rs1;
            issue_rs2     = ent_q[sel_idx].rs2;
            issue_rob_idx = ent_q[sel_idx].rob_idx;
            issue_ctrl    = ent_q[sel_idx].ctrl;
        end
    end

    always_comb begin
        new_ent.rd      = disp_rd;
        new_ent.rs1     = disp_rs1;
        new_ent.rs1_rdy = disp_rs1_rdy || (wb_valid && wb_preg == disp_rs1);
        new_ent.rs2     = disp_rs2;
        new_ent.rs2_rdy = disp_rs2_rdy || (wb_valid && wb_preg == disp_rs2);
        new_ent.rob_idx = disp_rob_idx;
        new_ent.ctrl    = disp_ctrl;
    end

    // One spare empty slot above the top so the shift needs no range guard.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_ext[i] = ent_q[i];
            vld_ext[i] = vld_q[i];
        end
        ent_ext[DEPTH] = '0;
        vld_ext[DEPTH] = 1'b0;
    end

    // Shift first, then wake at the new position, then drop in the dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && IDX_W'(i) >= sel_idx) begin
                ent_d[i] = ent_ext[i+1];
                vld_d[i] = vld_ext[i+1];
            end else begin
                ent_d[i] = ent_ext[i];
                vld_d[i] = vld_ext[i];
            end
            if (vld_d[i] && wb_valid) begin
                if (ent_d[i].rs1 == wb_preg) ent_d[i].rs1_rdy = 1'b1;
                if (ent_d[i].rs2 == wb_preg) ent_d[i].rs2_rdy = 1'b1;
            end
            if (disp_fire && widx == CNT_W'(i)) begin
                ent_d[i] = new_ent;
                vld_d[i] = 1'b1;
            end
        end
        cnt_d = cnt_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: per-cycle vector table plus
// hand-written fill/shift and flush sequences.
module tb_issue_queue;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_rd, disp_rs1, disp_rs2;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [5:0]  disp_rob_idx;
    logic [15:0] disp_ctrl;
    logic        wb_valid;
    logic [5:0]  wb_preg;
    logic        issue_valid, issue_ready;
    logic [5:0]  issue_rd, issue_rs1, issue_rs2, issue_rob_idx;
    logic [15:0] issue_ctrl;
    logic [3:0]  count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rd(disp_rd), .disp_rs1(disp_rs1),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2(disp_rs2),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rob_idx(disp_rob_idx),
        .disp_ctrl(disp_ctrl), .wb_valid(wb_valid), .wb_preg(wb_preg),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rob_idx(issue_rob_idx),
        .issue_ctrl(issue_ctrl), .count(count)
    );

    typedef struct packed {
        logic        rst;
        logic        dv;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic        r1;
        logic [5:0]  rs2;
        logic        r2;
        logic [5:0]  rob;
        logic [15:0] ctrl;
        logic        wbv;
        logic [5:0]  wbp;
        logic        ir;
        logic        e_dr;
        logic        e_iv;
        logic [5:0]  e_rd;
        logic [5:0]  e_rob;
        logic [15:0] e_ctrl;
        logic [3:0]  e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int wake_tag [7] = '{16, 17, 18, 20, 21, 22, 23};
    int wake_k   [7] = '{0, 1, 2, 4, 5, 6, 7};

    function automatic vec_t mk(
        input logic rst, input logic dv, input int rd, input int rs1,
        input logic r1, input int rs2, input logic r2, input int rob,
        input int ctrl, input logic wbv, input int wbp, input logic ir,
        input logic e_dr, input logic e_iv, input int e_rd,
        input int e_rob, input int e_ctrl, input int e_cnt);
        vec_t v;
        v.rst = rst; v.dv = dv; v.rd = 6'(rd); v.rs1 = 6'(rs1);
        v.r1 = r1; v.rs2 = 6'(rs2); v.r2 = r2; v.rob = 6'(rob);
        v.ctrl = 16'(ctrl); v.wbv = wbv; v.wbp = 6'(wbp); v.ir = ir;
        v.e_dr = e_dr; v.e_iv = e_iv; v.e_rd = 6'(e_rd);
        v.e_rob = 6'(e_rob); v.e_ctrl = 16'(e_ctrl); v.e_cnt = 4'(e_cnt);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input int rd, input int rs1,
                         input logic r1, input int rs2, input logic r2,
                         input int rob, input int ctrl, input logic wbv,
                         input int wbp, input logic ir, input logic fl);
        reset = 1'b0; flush = fl;
        disp_valid = dv; disp_rd = 6'(rd);
        disp_rs1 = 6'(rs1); disp_rs1_rdy = r1;
        disp_rs2 = 6'(rs2); disp_rs2_rdy = r2;
        disp_rob_idx = 6'(rob); disp_ctrl = 16'(ctrl);
        wb_valid = wbv; wb_preg = 6'(wbp); issue_ready = ir;
    endtask

    task automatic idle(input logic ir);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir, 0);
    endtask

    initial begin
        // rst dv  rd rs1 r1 rs2 r2 rob ctrl  wbv wbp ir | dr iv rd rob ctrl cnt
        vecs[0]  = mk(1, 1, 10, 3, 1, 4, 1, 5, 'h00AB, 0, 0, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 10, 3, 1, 4, 1, 5, 'h00AB, 0, 0, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 1, 10, 5, 'h00AB, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 20, 7, 0, 8, 1, 1, 'h1111, 0, 0, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 21, 1, 1, 2, 1, 2, 'h2222, 0, 0, 0,
                      1, 0, 0, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 1, 21, 2, 'h2222, 2);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1,
                      1, 0, 0, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      1, 1, 20, 1, 'h1111, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 1, 20, 1, 'h1111, 1);
        vecs[11] = mk(0, 1, 30, 5, 1, 9, 0, 3, 'h0303, 1, 9, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 1, 30, 3, 'h0303, 1);
        vecs[13] = mk(0, 1, 40, 11, 0, 12, 1, 4, 'h4444, 0, 0, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 41, 1, 1, 2, 1, 6, 'h4545, 0, 0, 0,
                      1, 0, 0, 0, 0, 1);
        vecs[15] = mk(0, 1, 42, 13, 0, 14, 0, 7, 'h4646, 1, 11, 1,
                      1, 1, 41, 6, 'h4545, 2);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0,
                      1, 1, 40, 4, 'h4444, 2);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 1,
                      1, 1, 40, 4, 'h4444, 2);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 1, 42, 7, 'h4646, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0);

        idle(0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].dv, int'(vecs[i].rd), int'(vecs[i].rs1),
                  vecs[i].r1, int'(vecs[i].rs2), vecs[i].r2,
                  int'(vecs[i].rob), int'(vecs[i].ctrl), vecs[i].wbv,
                  int'(vecs[i].wbp), vecs[i].ir, 0);
            reset = vecs[i].rst;
            #1;
            chk($sformatf("v%0d_disp_ready", i), 32'(disp_ready), 32'(vecs[i].e_dr));
            chk($sformatf("v%0d_issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
            chk($sformatf("v%0d_issue_rd", i), 32'(issue_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_issue_rob", i), 32'(issue_rob_idx), 32'(vecs[i].e_rob));
            chk($sformatf("v%0d_issue_ctrl", i), 32'(issue_ctrl), 32'(vecs[i].e_ctrl));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
        end

        // Fill with eight entries whose rs1 is pending.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1, 50 + k, 16 + k, 0, 32 + k, 1, 8 + k, 'h5000 + k,
                  0, 0, 0, 0);
            #1 chk($sformatf("fill%0d_count", k), 32'(count), 32'(k));
        end
        @(negedge clk);
        drive(1, 63, 1, 1, 2, 1, 63, 'hFFFF, 0, 0, 0, 0);
        #1;
        chk("full_count", 32'(count), 32'd8);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_issue_valid", 32'(issue_valid), 32'd0);
        @(negedge clk);
        drive(1, 63, 1, 1, 2, 1, 63, 'hFFFF, 1, 19, 1, 0);
        #1;
        chk("full_blocked_count", 32'(count), 32'd8);
        chk("wake_same_cycle_iv", 32'(issue_valid), 32'd0);
        @(negedge clk);
        drive(1, 63, 1, 1, 2, 1, 63, 'hFFFF, 0, 0, 1, 0);
        #1;
        chk("e3_issue_valid", 32'(issue_valid), 32'd1);
        chk("e3_issue_rd", 32'(issue_rd), 32'd53);
        chk("e3_issue_rob", 32'(issue_rob_idx), 32'd11);
        chk("e3_issue_ctrl", 32'(issue_ctrl), 32'h5003);
        chk("e3_issue_rs1", 32'(issue_rs1), 32'd19);
        chk("e3_issue_rs2", 32'(issue_rs2), 32'd35);
        @(negedge clk);
        idle(0);
        #1;
        chk("post_issue_count", 32'(count), 32'd7);
        chk("post_issue_disp_ready", 32'(disp_ready), 32'd1);
        chk("post_issue_iv", 32'(issue_valid), 32'd0);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, wake_tag[j], 0, 0);
        end
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            idle(1);
            #1;
            chk($sformatf("drain%0d_iv", j), 32'(issue_valid), 32'd1);
            chk($sformatf("drain%0d_rd", j), 32'(issue_rd), 32'(50 + wake_k[j]));
            chk($sformatf("drain%0d_rob", j), 32'(issue_rob_idx), 32'(8 + wake_k[j]));
            chk($sformatf("drain%0d_ctrl", j), 32'(issue_ctrl), 32'('h5000 + wake_k[j]));
            chk($sformatf("drain%0d_count", j), 32'(count), 32'(7 - j));
        end
        @(negedge clk);
        idle(0);
        #1 chk("drained_count", 32'(count), 32'd0);

        // Flush beats a simultaneous dispatch and issue.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, k + 1, 0, 1, 0, 1, k, k, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 60, 1, 1, 2, 1, 60, 'h6060, 0, 0, 1, 1);
        #1;
        chk("pre_flush_count", 32'(count), 32'd5);
        chk("pre_flush_rd", 32'(issue_rd), 32'd1);
        @(negedge clk);
        idle(0);
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_iv", 32'(issue_valid), 32'd0);
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        @(negedge clk);
        idle(1);
        #1;
        chk("flush_absent_iv", 32'(issue_valid), 32'd0);
        chk("flush_absent_rd", 32'(issue_rd), 32'd0);
        chk("flush_absent_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Renamed-instruction issue queue between the rename stage and the execute/ALU stage.
- Buffers up to DEPTH micro-ops with physical source tags and per-source ready bits.
- Listens to a single writeback tag broadcast per cycle to wake up dependants.
- Each cycle, presents the oldest micro-op with both sources ready to execute over a valid/ready handshake. Storage is a compacting array, so index 0 is always the oldest entry.

Parameters:
- DEPTH, 8, number of entries (power of two, >=2)
- PREG_W, 6, physical register tag width
- ROB_W, 6, ROB index width
- CTRL_W, 16, opaque control payload (opcode/funct/imm select) carried through unchanged

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous reset, active-high
- flush  in  1  discard all entries (mispredict/exception)
- disp_valid  in  1  rename presents a micro-op
- disp_ready  out  1  queue can accept
- disp_rd  in  PREG_W  destination physical register
- disp_rs1  in  PREG_W  source 1 physical register
- disp_rs1_rdy  in  1  source 1 value already available
- disp_rs2  in  PREG_W  source 2 physical register
- disp_rs2_rdy  in  1  source 2 value already available
- disp_rob_idx  in  ROB_W  ROB slot of the micro-op
- disp_ctrl  in  CTRL_W  control payload
- wb_valid  in  1  writeback tag broadcast valid
- wb_preg  in  PREG_W  physical register just written
- issue_valid  out  1  a ready micro-op is presented
- issue_ready  in  1  execute stage accepts
- issue_rd / issue_rs1 / issue_rs2  out  PREG_W each  fields of the presented entry
- issue_rob_idx  out  ROB_W  field of the presented entry
- issue_ctrl  out  CTRL_W  field of the presented entry
- count  out  clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Entry state: valid, rd, rs1, rs1_rdy, rs2, rs2_rdy, rob_idx, ctrl. Entries 0..count-1 are valid; higher entries are invalid.
- Reset (and flush): count=0, all valid and ready bits cleared.
  - Outputs after reset: disp_ready=1, issue_valid=0, count=0, all issue_* payload outputs 0.
  - flush has priority over dispatch, issue and wakeup in the same cycle. A dispatch or issue handshake in that cycle is discarded and nothing is retained.
- disp_ready = (count < DEPTH). It is combinational from count only; there is no credit for a same-cycle issue.
- Dispatch fires when disp_valid && disp_ready. The new entry is written at index count, or count-1 if an issue fires in the same cycle.
- Dispatch bypass: an entry's rsN_rdy is stored as disp_rsN_rdy OR (wb_valid && wb_preg==disp_rsN). This covers a wakeup in the same cycle as the dispatch.
- Wakeup: in a cycle with wb_valid, every valid entry whose rsN == wb_preg sets rsN_rdy=1 at the edge. Multiple entries and both sources may match at once.
- Select (combinational):
  - Find the lowest index i with valid && rs1_rdy && rs2_rdy.
  - issue_valid=1 and issue_* = entry i fields. If no entry qualifies, issue_valid=0 and issue_* = 0.
  - Ready bits set at an edge are visible to select in the following cycle, so wakeup-to-issue latency is 1 cycle. The earliest a dispatched micro-op can issue is the cycle after dispatch.
- Issue fires when issue_valid && issue_ready.
  - Entry i is removed, entries i+1..count-1 shift down by one and keep their ready bits.
  - A wakeup in the same cycle applies to the shifted entries at their new positions.
  - Wakeup is never lost through the shift.
- count next = count + dispatch_fire - issue_fire.
  - Full with a simultaneous issue: dispatch is still blocked because disp_ready=0. count becomes DEPTH-1.
  - Empty with a simultaneous dispatch: issue cannot fire because the array is empty. count becomes 1.
- Holding rules:
  - issue_* are stable while issue_valid && !issue_ready, unless an older entry becomes ready. Select is always oldest-ready.
  - Payload bits are never modified inside the queue.
- A disp_valid with disp_ready=0 has no effect. Upstream holds the micro-op.
- Arithmetic: tag compares are full PREG_W equality. There is no special-casing of tag 0; rename supplies disp_rsN_rdy=1 for x0.

Test Plan:
- Reset: assert reset 2 cycles -> disp_ready=1, issue_valid=0, count=0, issue_rd=0. Dispatch during reset -> not retained.
- Dispatch rd=10, rs1=3 rdy=1, rs2=4 rdy=1, rob=5, ctrl=0x00AB at cycle t -> at t+1 issue_valid=1, issue_rd=10, issue_rob_idx=5, issue_ctrl=0x00AB. issue_ready=1 -> count returns to 0 at t+2.
- Dispatch A (rs1=7 rdy=0), then B (all ready) -> B issues first. wb_valid, wb_preg=7 at cycle t -> A issue_valid at t+1, not t.
- Dispatch with disp_rs2=9 rdy=0 while wb_valid, wb_preg=9 in the same cycle -> entry issues the next cycle.
- Fill 8 entries all not ready -> count=8, disp_ready=0, issue_valid=0.
  - Wake entry 3 -> entry 3 issues.
  - Entries 4..7 shift to 3..6 with fields intact; count=7, disp_ready=1.
- 5 entries present; flush together with disp_valid and issue_ready -> next cycle count=0, issue_valid=0, dispatched op absent.
